// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for the CDC FIFO write port (write clock domain).
// Optional: define FIFO_ARB_PRIO0_EN to give requester 0 strict priority.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int BURST_LEN   = 4,
    parameter int OWNER_WIDTH = 2
) (
    input  logic                          write_clock,
    input  logic                          write_reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          full,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic                          write_increment,
    output logic                          busy,
    output logic [OWNER_WIDTH-1:0]        owner
);

    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                 state_q, state_d;
    logic [OWNER_WIDTH-1:0] owner_q, owner_d;
    logic [OWNER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0]     req_rot;
    logic [OWNER_WIDTH-1:0] pick;
    logic                   found;
    logic                   owner_req;
    logic [DATA_WIDTH-1:0]  owner_data;
    logic                   wr;
    logic [OWNER_WIDTH-1:0] owner_next;
    int                     off;
    int                     sum;

    // Rotate so that bit 0 is the requester at rr_ptr; first set bit wins.
    always_comb begin
        req_rot = NUM_REQ'({req, req} >> rr_ptr_q);
        found   = 1'b0;
        off     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(rr_ptr_q) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        pick = OWNER_WIDTH'(sum);
`ifdef FIFO_ARB_PRIO0_EN
        if (req[0]) begin
            pick = '0;
        end
`endif
    end

    always_comb begin
        owner_req  = 1'(req >> owner_q);
        owner_data = DATA_WIDTH'(req_data >> (int'(owner_q) * DATA_WIDTH));
        busy       = (state_q == BURST);
        // Reset cycle never writes, even when abandoning a burst.
        wr         = busy & owner_req & ~full & ~write_reset;

        write_increment = wr;
        write_data      = busy ? owner_data : '0;
        ack             = wr ? (NUM_REQ'(1) << owner_q) : '0;
        owner           = owner_q;

        if (owner_q == OWNER_WIDTH'(NUM_REQ - 1)) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BURST;
                    owner_d     = pick;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (!owner_req ||
                    (wr && burst_cnt_q == CNT_W'(BURST_LEN - 1))) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
`ifdef FIFO_ARB_PRIO0_EN
                    if (owner_q != '0) begin
                        rr_ptr_d = owner_next;
                    end
`else
                    rr_ptr_d = owner_next;
`endif
                end else if (wr) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge write_clock) begin
        if (write_reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule
